// File: rtl/line_buf_tap_if.sv
// RAM-side port bundle between line_buf_tap (master) and the line_buf simple-dual-port RAM (slave).
// Write is a plain strobe: the RAM stores ram_wr_data at ram_wr_addr on every clk edge where ram_wr_en=1; reads never stall.
interface line_buf_tap_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic [DATA_W-1:0] ram_wr_data;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (
        output ram_wr_data,
        output ram_wr_addr,
        output ram_wr_en,
        output ram_rd_addr,
        input  ram_rd_data
    );

    modport slave (
        input  ram_wr_data,
        input  ram_wr_addr,
        input  ram_wr_en,
        input  ram_rd_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/line_buf_tap.sv
// Line-buffer controller: writes each active line into the line RAM and pairs every output pixel
// with the pixel at the same column of the previous line.
module line_buf_tap #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 11,
    parameter int VS_POL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vs,
    input  logic              i_hs,
    input  logic              i_de,
    input  logic [DATA_W-1:0] i_data,
    line_buf_tap_if.master    ram,
    output logic              o_vs,
    output logic              o_hs,
    output logic              o_de,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-1:0] o_prev,
    output logic              o_prev_vld,
    output logic [ADDR_W-1:0] o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic              o_ovf
);
    localparam logic              VS_ACT   = (VS_POL != 0);
    localparam logic [ADDR_W-1:0] COL_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ROW_W-1:0]  ROW_MAX  = {ROW_W{1'b1}};

    logic [ADDR_W-1:0] col_q, col_d;
    logic              sat_q, sat_d;
    logic              armed_q;
    logic [ADDR_W:0]   last_len_q;
    logic [ROW_W-1:0]  row_q;
    logic              vs_q, hs_q, de_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] ocol_q;
    logic [ROW_W-1:0]  orow_q;
    logic              vld_q, ovf_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              de_eff, frame_start, line_end, ovf_pix, prev_ok;
    logic [ADDR_W:0]   len_now;

    // A line cut by reset is ignored until i_de drops, so the next full line is row 0.
    assign de_eff      = i_de & armed_q;
    assign frame_start = (i_vs == VS_ACT) & (vs_q != VS_ACT);
    assign line_end    = de_q & ~de_eff;
    assign ovf_pix     = de_eff & sat_q;
    assign len_now     = sat_q ? LEN_FULL : {1'b0, col_q};
    assign prev_ok     = de_eff & (row_q != '0) & ({1'b0, col_q} < last_len_q) & ~sat_q;

    always_comb begin
        col_d = col_q;
        sat_d = sat_q;
        if (!de_eff) begin
            col_d = '0;
            sat_d = 1'b0;
        end else if (col_q == COL_MAX) begin
            sat_d = 1'b1;
        end else begin
            col_d = col_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            sat_q      <= 1'b0;
            armed_q    <= 1'b0;
            last_len_q <= '0;
            row_q      <= '0;
            vs_q       <= 1'b0;
            hs_q       <= 1'b0;
            de_q       <= 1'b0;
            data_q     <= '0;
            ocol_q     <= '0;
            orow_q     <= '0;
            vld_q      <= 1'b0;
            ovf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            armed_q   <= armed_q | ~i_de;
            col_q     <= col_d;
            sat_q     <= sat_d;
            vs_q      <= i_vs;
            hs_q      <= i_hs;
            de_q      <= de_eff;
            data_q    <= i_data;
            ocol_q    <= col_q;
            orow_q    <= row_q;
            vld_q     <= prev_ok;
            wr_en_q   <= de_eff & ~sat_q;
            wr_addr_q <= col_q;
            wr_data_q <= i_data;
            if (line_end) begin
                last_len_q <= len_now;
                if (row_q != ROW_MAX) row_q <= row_q + 1'b1;
            end
            if (ovf_pix) ovf_q <= 1'b1;
            // Frame start overrides a coincident line end and overflow.
            if (frame_start) begin
                row_q      <= '0;
                last_len_q <= '0;
                ovf_q      <= 1'b0;
            end
        end
    end

    assign ram.ram_rd_addr = col_q;
    assign ram.ram_wr_en   = wr_en_q;
    assign ram.ram_wr_addr = wr_addr_q;
    assign ram.ram_wr_data = wr_data_q;

    assign o_vs       = vs_q;
    assign o_hs       = hs_q;
    assign o_de       = de_q;
    assign o_data     = data_q;
    assign o_prev     = ram.ram_rd_data;
    assign o_prev_vld = vld_q;
    assign o_col      = ocol_q;
    assign o_row      = orow_q;
    assign o_ovf      = ovf_q;
endmodule
